wb_port_arbiter: RTL and testbench

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/PARAMS_pkg.sv | 13 +
 rtl/wb_result_fifo.sv | 51 +++++
 rtl/wb_port_arbiter.sv | 87 ++++++++
 tb/tb_wb_port_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/PARAMS_pkg.sv
// Shared core parameters and the write-back request type used by the
// result queue and the register-file grant mux.
package PARAMS_pkg;

  localparam int WD_SIZE        = 32;
  localparam int INSTR_REG_BITS = 5;

  typedef struct packed {
    logic [INSTR_REG_BITS-1:0] rd;
    logic [WD_SIZE-1:0]        data;
  } wb_req_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Small circular FIFO holding long-latency results until the write-back
// arbiter grants them a register-file port.
module wb_result_fifo
  import PARAMS_pkg::*;
#(
  parameter int QDEPTH = 2,
  parameter int CW     = $clog2(QDEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  wb_req_t       din,
  output wb_req_t       head,
  output logic [CW-1:0] count
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  wb_req_t       mem [QDEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head = mem[rd_ptr];

  // The arbiter never pushes when full or pops when empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (pop)
        rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Single register-file write port shared by the write-back stage and a queue
// of long-latency results. Define WB_STARVE_GUARD_EN to add the age guard.
module wb_port_arbiter
  import PARAMS_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int QDEPTH     = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      pipe_valid_i,
  input  logic [INSTR_REG_BITS-1:0] pipe_rd_i,
  input  logic [WD_SIZE-1:0]        pipe_data_i,
  input  logic                      lu_valid_i,
  input  logic [INSTR_REG_BITS-1:0] lu_rd_i,
  input  logic [WD_SIZE-1:0]        lu_data_i,
  output logic                      lu_ready_o,
  output logic                      stall_o,
  output logic                      rf_we_o,
  output logic [INSTR_REG_BITS-1:0] rf_waddr_o,
  output logic [WD_SIZE-1:0]        rf_wdata_o
);

  localparam int CW = $clog2(QDEPTH + 1);

  wb_req_t       q_head;
  wb_req_t       sel;
  logic [CW-1:0] q_count;
  logic          q_nonempty;
  logic          push;
  logic          forced;
  logic          waw;
  logic          grant_q;
  logic          grant_p;

  assign q_nonempty = (q_count != '0);
  assign lu_ready_o = !reset_n && (q_count < CW'(QDEPTH));
  assign push       = lu_valid_i && lu_ready_o;

  wb_result_fifo #(.QDEPTH(QDEPTH), .CW(CW)) u_fifo (
    .clk   (clk),
    .reset (reset_n),
    .push  (push),
    .pop   (grant_q),
    .din   ({lu_rd_i, lu_data_i}),
    .head  (q_head),
    .count (q_count)
  );

`ifdef WB_STARVE_GUARD_EN
  localparam int AW = $clog2(STARVE_MAX + 1);
  logic [AW-1:0] age;

  assign forced = q_nonempty && (age == AW'(STARVE_MAX));

  always_ff @(posedge clk) begin
    if (reset_n || !q_nonempty || grant_q)
      age <= '0;
    else if (age != AW'(STARVE_MAX))
      age <= age + 1'b1;
  end
`else
  assign forced = 1'b0;
`endif

  // A queued write to the same register as the pipe result must land first.
  assign waw     = q_nonempty && pipe_valid_i && (q_head.rd == pipe_rd_i);
  assign grant_q = !reset_n && (forced || waw || (q_nonempty && !pipe_valid_i));
  assign grant_p = !reset_n && !grant_q && pipe_valid_i;
  assign stall_o = !reset_n && pipe_valid_i && !grant_p;
  assign sel     = grant_q ? q_head : wb_req_t'({pipe_rd_i, pipe_data_i});

  always_ff @(posedge clk) begin
    if (reset_n) begin
      rf_we_o    <= 1'b0;
      rf_waddr_o <= '0;
      rf_wdata_o <= '0;
    end else begin
      rf_we_o <= (grant_q || grant_p) && (sel.rd != '0);
      if (grant_q || grant_p) begin
        rf_waddr_o <= sel.rd;
        rf_wdata_o <= sel.data;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed-vector bench for wb_port_arbiter; expectations follow the macro
// WB_STARVE_GUARD_EN so the same bench covers both builds.
module tb_wb_port_arbiter;
  import PARAMS_pkg::*;

  logic                      clk = 1'b0;
  logic                      reset_n;
  logic                      pipe_valid_i;
  logic [INSTR_REG_BITS-1:0] pipe_rd_i;
  logic [WD_SIZE-1:0]        pipe_data_i;
  logic                      lu_valid_i;
  logic [INSTR_REG_BITS-1:0] lu_rd_i;
  logic [WD_SIZE-1:0]        lu_data_i;
  logic                      lu_ready_o;
  logic                      stall_o;
  logic                      rf_we_o;
  logic [INSTR_REG_BITS-1:0] rf_waddr_o;
  logic [WD_SIZE-1:0]        rf_wdata_o;

  int checks   = 0;
  int failures = 0;

  wb_port_arbiter #(.STARVE_MAX(4), .QDEPTH(2)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pipe_valid_i (pipe_valid_i),
    .pipe_rd_i    (pipe_rd_i),
    .pipe_data_i  (pipe_data_i),
    .lu_valid_i   (lu_valid_i),
    .lu_rd_i      (lu_rd_i),
    .lu_data_i    (lu_data_i),
    .lu_ready_o   (lu_ready_o),
    .stall_o      (stall_o),
    .rf_we_o      (rf_we_o),
    .rf_waddr_o   (rf_waddr_o),
    .rf_wdata_o   (rf_wdata_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic pv, input logic [4:0] prd, input logic [31:0] pdata,
                               input logic lv, input logic [4:0] lrd, input logic [31:0] ldata);
    pipe_valid_i = pv;
    pipe_rd_i    = prd;
    pipe_data_i  = pdata;
    lu_valid_i   = lv;
    lu_rd_i      = lrd;
    lu_data_i    = ldata;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_write(input string tag, input logic [4:0] rd, input logic [31:0] data);
    checkOutput({tag, "_we"},    rf_we_o,    1'b1);
    checkOutput({tag, "_waddr"}, rf_waddr_o, rd);
    checkOutput({tag, "_wdata"}, rf_wdata_o, data);
  endtask

  initial begin
    reset_n = 1'b1;
    applyStimulus(1'b1, 5'd5, 32'h1, 1'b1, 5'd3, 32'h2);
    step();
    step();
    checkOutput("rst_ready", lu_ready_o, 1'b0);
    checkOutput("rst_stall", stall_o,    1'b0);
    checkOutput("rst_we",    rf_we_o,    1'b0);
    checkOutput("rst_waddr", rf_waddr_o, 5'd0);
    checkOutput("rst_wdata", rf_wdata_o, 32'h0);

    reset_n = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("post_rst_ready", lu_ready_o, 1'b1);

    // pipe only
    applyStimulus(1'b1, 5'd5, 32'hA5, 1'b0, 5'd0, 32'h0);
    checkOutput("pipe_stall", stall_o, 1'b0);
    step();
    expect_write("pipe", 5'd5, 32'hA5);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step();
    checkOutput("idle_we",    rf_we_o,    1'b0);
    checkOutput("idle_waddr", rf_waddr_o, 5'd5);
    checkOutput("idle_wdata", rf_wdata_o, 32'hA5);

    // contention: queued rd=3 yields to pipe rd=7
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h33);
    step();
    checkOutput("nocut_we", rf_we_o, 1'b0);
    applyStimulus(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'h0);
    checkOutput("cont_stall", stall_o, 1'b0);
    step();
    expect_write("cont_pipe", 5'd7, 32'h77);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step();
    expect_write("cont_q", 5'd3, 32'h33);
    step();
    checkOutput("cont_idle_we", rf_we_o, 1'b0);

    // WAW on rd=9
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99);
    step();
    applyStimulus(1'b1, 5'd9, 32'h9A, 1'b0, 5'd0, 32'h0);
    checkOutput("waw_stall", stall_o, 1'b1);
    step();
    expect_write("waw_lu", 5'd9, 32'h99);
    checkOutput("waw_stall2", stall_o, 1'b0);
    step();
    expect_write("waw_pipe", 5'd9, 32'h9A);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step();

    // full queue and producer hold
    applyStimulus(1'b1, 5'd1, 32'h11, 1'b1, 5'd4, 32'h44);
    step();
    applyStimulus(1'b1, 5'd1, 32'h12, 1'b1, 5'd6, 32'h66);
    step();
    expect_write("full_pipe", 5'd1, 32'h12);
    applyStimulus(1'b1, 5'd1, 32'h13, 1'b1, 5'd8, 32'h88);
    checkOutput("full_ready", lu_ready_o, 1'b0);
    step();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 32'h88);
    checkOutput("full_ready_pop", lu_ready_o, 1'b0);
    step();
    expect_write("full_q4", 5'd4, 32'h44);
    checkOutput("full_ready_after", lu_ready_o, 1'b1);
    step();
    expect_write("full_q6", 5'd6, 32'h66);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step();
    expect_write("full_q8", 5'd8, 32'h88);
    step();
    checkOutput("full_drained_we", rf_we_o, 1'b0);

    // starvation of rd=2 under continuous pipe traffic
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 32'h22);
    step();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 5'd1, 32'h100 + i, 1'b0, 5'd0, 32'h0);
      checkOutput($sformatf("starve_stall%0d", i), stall_o, 1'b0);
      step();
      expect_write($sformatf("starve_pipe%0d", i), 5'd1, 32'h100 + i);
    end
    applyStimulus(1'b1, 5'd1, 32'h104, 1'b0, 5'd0, 32'h0);
`ifdef WB_STARVE_GUARD_EN
    checkOutput("starve_forced_stall", stall_o, 1'b1);
    step();
    expect_write("starve_forced", 5'd2, 32'h22);
    checkOutput("starve_resume_stall", stall_o, 1'b0);
    step();
    expect_write("starve_resume", 5'd1, 32'h104);
`else
    checkOutput("starve_nostall", stall_o, 1'b0);
    step();
    expect_write("starve_pipe4", 5'd1, 32'h104);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step();
    expect_write("starve_idle_q", 5'd2, 32'h22);
`endif
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step();

    // x0 discard
    applyStimulus(1'b1, 5'd0, 32'hFF, 1'b0, 5'd0, 32'h0);
    checkOutput("x0_stall", stall_o, 1'b0);
    step();
    checkOutput("x0_we", rf_we_o, 1'b0);

    // reset with two queued entries
    applyStimulus(1'b1, 5'd1, 32'h21, 1'b1, 5'd10, 32'hAA);
    step();
    applyStimulus(1'b1, 5'd1, 32'h22, 1'b1, 5'd11, 32'hBB);
    step();
    reset_n = 1'b1;
    applyStimulus(1'b1, 5'd1, 32'h23, 1'b1, 5'd12, 32'hCC);
    checkOutput("midrst_ready", lu_ready_o, 1'b0);
    checkOutput("midrst_stall", stall_o,    1'b0);
    step();
    checkOutput("midrst_we",    rf_we_o,    1'b0);
    checkOutput("midrst_waddr", rf_waddr_o, 5'd0);
    reset_n = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("midrst_ready_after", lu_ready_o, 1'b1);
    step();
    checkOutput("midrst_empty_we", rf_we_o, 1'b0);
    step();
    checkOutput("midrst_empty_we2", rf_we_o, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
